// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch feeding decode through a 2-entry {instr, pc} buffer.
// Define FETCH_MISALIGN_CHECK_EN to trap misaligned redirects (fetch_fault + HALT); otherwise targets are word-aligned.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nreset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        fetch_fault
);

  // state   | meaning
  // REQ     | requesting pc from instruction memory
  // WAIT    | one request outstanding, response goes into the buffer
  // DISCARD | one request outstanding, response is dropped (redirected)
  // FULL    | buffer holds two entries, fetching paused
  // HALT    | misaligned redirect trapped, idle until reset
  typedef enum logic [2:0] {S_REQ, S_WAIT, S_DISCARD, S_FULL, S_HALT} state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx, req_pc;
  logic        run;
  logic [31:0] buf_instr [2];
  logic [31:0] buf_pc    [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count, count_nx, occ_after;
  logic        push, pop, flush, load_req, gnt_take;
  logic [31:0] redir_tgt;
  logic        redir_bad;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redir_tgt = redirect_pc;
  assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign redir_tgt = redirect_pc & 32'hFFFF_FFFC;
  assign redir_bad = 1'b0;
`endif

  // run holds the request low until the first edge after reset release
  assign imem_req  = (state == S_REQ) && run;
  assign imem_addr = pc;
  assign gnt_take  = imem_req && imem_gnt;

  assign id_valid  = (count != 2'd0);
  assign id_instr  = buf_instr[rd_ptr];
  assign id_pc     = buf_pc[rd_ptr];
  assign pop       = id_valid && id_ready;
  assign wr_ptr    = rd_ptr ^ count[0];
  assign occ_after = count + 2'd1 - {1'b0, pop};

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    push     = 1'b0;
    flush    = 1'b0;
    load_req = 1'b0;
    if (state == S_HALT) begin
      state_nx = S_HALT;
    end else if (redir_bad) begin
      flush    = 1'b1;
      state_nx = S_HALT;
    end else if (redirect_valid) begin
      flush = 1'b1;
      pc_nx = redir_tgt;
      case (state)
        S_REQ:             state_nx = gnt_take ? S_DISCARD : S_REQ;
        // a response landing with the redirect retires the outstanding request
        S_WAIT, S_DISCARD: state_nx = imem_rvalid ? S_REQ : S_DISCARD;
        default:           state_nx = S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: if (gnt_take) begin
          load_req = 1'b1;
          pc_nx    = pc + 32'd4;
          state_nx = S_WAIT;
        end
        S_WAIT: if (imem_rvalid) begin
          push     = 1'b1;
          state_nx = (occ_after == 2'd2) ? S_FULL : S_REQ;
        end
        S_DISCARD: if (imem_rvalid) state_nx = S_REQ;
        S_FULL:    if (pop) state_nx = S_REQ;
        default:   state_nx = state;
      endcase
    end
    count_nx = flush ? 2'd0 : (count + {1'b0, push} - {1'b0, pop});
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= S_REQ;
    else         state <= state_nx;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
      run    <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_instr[i] <= '0;
        buf_pc[i]    <= '0;
      end
    end else begin
      run   <= 1'b1;
      pc    <= pc_nx;
      count <= count_nx;
      if (load_req) req_pc <= pc;
      if (pop)      rd_ptr <= ~rd_ptr;
      if (push) begin
        buf_instr[wr_ptr] <= imem_rdata;
        buf_pc[wr_ptr]    <= req_pc;
      end
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q;
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)        fault_q <= 1'b0;
    else if (redir_bad) fault_q <= 1'b1;
  end
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

endmodule
